addr_range_decoder_seq: RTL and testbench
=========================================

Name: addr_range_decoder_seq

Overview:
- Parametrised, sequential successor to the static chip-select decoder.
- Holds NUM_CS programmable address windows, each defined by base, mask, wait-state count and enable.
- Runs a req/ack bus-cycle state machine: latches the address, decodes it, asserts one chip select, inserts per-window wait states, then acks.
- Sits between the CPU bus interface and the ROM/SRAM/DRAM chip selects; unmapped accesses return bus_err.

Parameters:
- ADDR_W, 32, bus address width.
- NUM_CS, 4, number of windows/chip selects; minimum 1.
- WS_W, 4, width of each wait-state count.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_req  in  1  access request; held high until bus_ack or bus_err is sampled.
- bus_addr  in  ADDR_W  access address; sampled only in IDLE when bus_req=1.
- bus_ack  out  1  one-cycle access-complete pulse.
- bus_err  out  1  one-cycle unmapped-address pulse.
- cs_out  out  NUM_CS  active-high chip selects, registered, one-hot or zero.
- busy  out  1  high in any state other than IDLE.
- cfg_we  in  1  window-table write strobe.
- cfg_idx  in  $clog2(NUM_CS) (min 1)  window index to write.
- cfg_base  in  ADDR_W  window base address.
- cfg_mask  in  ADDR_W  window compare mask; 1 = bit compared.
- cfg_ws  in  WS_W  wait states for the window.
- cfg_en  in  1  window enable.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - state=IDLE; cs_out=0; bus_ack=0; bus_err=0; busy=0; wait counter=0.
  - Window 0 (ROM): base FFF00000, mask FFF80000, ws 2, enabled.
  - Window 1 (SRAM): base 00000000, mask FFF80000, ws 0, enabled.
  - Window 2 (DRAM): base C0000000, mask FFF80000, ws 4, enabled.
  - Windows 3 and above: disabled, all fields 0.
  - If ADDR_W<32 or NUM_CS<3, the reset constants are truncated or dropped.
- Window match rule:
  - Window k matches when en[k]=1 and (addr & mask[k]) == (base[k] & mask[k]).
  - When several windows match, the lowest index wins.
  - A mask of 0 on an enabled window matches every address.
- State machine IDLE, DECODE, WAIT, DONE, ERR:
  - IDLE: if bus_req=1, latch bus_addr and go to DECODE; otherwise stay.
  - DECODE (1 cycle): with a match on window k, set cs_out=1<<k, load counter=ws[k], go to WAIT. With no match, go to ERR and keep cs_out=0.
  - WAIT: cs_out held. If counter==0, go to DONE; otherwise decrement.
  - DONE: bus_ack=1 and cs_out still held for this cycle; next edge goes to IDLE and clears cs_out.
  - ERR: bus_err=1 for one cycle; next edge goes to IDLE.
- Latency, taking edge E0 as the edge that samples bus_req in IDLE:
  - cs_out rises after E1.
  - bus_ack is high in the cycle after E(ws+2).
  - cs_out falls after E(ws+3).
  - An unmapped address gives bus_err high in the cycle after E1.
- Handshake rules:
  - The requester drops bus_req on the edge at which it samples ack or err.
  - A request held high through IDLE starts a new cycle; this is legal back-to-back behaviour.
- Abort: bus_req=0 in DECODE or WAIT sends the next edge to IDLE. cs_out clears, no ack, no err.
- Configuration writes:
  - Take effect on the edge cfg_we=1 and are legal in any state.
  - A cycle already in progress keeps its latched channel and counter; the new values affect only later decodes.
  - A write during DECODE is not visible to that decode.
- Reset asserted mid-cycle returns immediately to the reset state, including the window table.
- bus_ack and bus_err are never high together; cs_out is never multi-hot.

Decomposition:
- Package addr_decode_pkg holds:
  - the state enum;
  - reset-window constants (base/mask/ws/en per index 0-2);
  - a struct for one window entry.
- Sub-module addr_window_match: purely combinational.
  - Inputs: address and the window table.
  - Outputs: hit flag, winning index, and that window's ws.
  - Contains the per-window compare and the priority encoder.

Test Plan:
- After reset, req with addr FFF01234 → cs_out=0001 after E1, bus_ack in the cycle after E4, cs_out=0 after E5.
- req with addr 00000010 (ws 0) → cs_out=0010 after E1, ack in the cycle after E2. Then hold req with addr C0000000 → cs_out=0100, ack 4 cycles later than the SRAM ack timing.
- req with addr 80000000 → bus_err single pulse in the cycle after E1, cs_out stays 0, no ack.
- Write window 3 with base 80000000, mask F0000000, ws 1, en 1; then req with addr 80000004 → cs_out=1000, ack in the cycle after E3. Then write window 1 with mask 00000000 → addr 80000004 now selects window 1 (priority).
- Drop req during WAIT of a ROM access → cs_out clears next edge, no ack. Assert reset during WAIT → outputs 0 immediately and window 3 is disabled again.

Source files
------------

// File: rtl/addr_decode_pkg.sv
// addr_decode_pkg: shared types and constants for the sequential address
// range decoder.
//   state_t       bus-cycle FSM states
//   win_cfg_t     one window table entry (32-bit base/mask, 8-bit ws, enable)
//   rst_win()     power-on contents of window k (windows 3+ are disabled, zero)
//   cs_idx_w()    width of a chip-select index (at least 1 bit)
package addr_decode_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_WAIT,
      ST_DONE,
      ST_ERR
   } state_t;

   typedef struct packed {
      logic [31:0] base;
      logic [31:0] mask;
      logic [7:0]  ws;
      logic        en;
   } win_cfg_t;

   // ROM, SRAM, DRAM windows. Callers truncate/extend to their own widths.
   function automatic win_cfg_t rst_win(input int idx);
      win_cfg_t w;
      w = '0;
      case (idx)
         0: w = '{base: 32'hFFF0_0000, mask: 32'hFFF8_0000, ws: 8'd2, en: 1'b1};
         1: w = '{base: 32'h0000_0000, mask: 32'hFFF8_0000, ws: 8'd0, en: 1'b1};
         2: w = '{base: 32'hC000_0000, mask: 32'hFFF8_0000, ws: 8'd4, en: 1'b1};
         default: w = '0;
      endcase
      return w;
   endfunction

   function automatic int cs_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/addr_window_match.sv
// addr_window_match: combinational window compare + priority encoder.
//   addr                      address to decode
//   win_base/mask/ws/en       window table, one entry per chip select
//   hit                       at least one enabled window matches
//   hit_idx                   lowest matching window index (0 when no hit)
//   hit_ws                    wait-state count of that window (0 when no hit)
module addr_window_match
   import addr_decode_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int NUM_CS = 4,
   parameter int WS_W   = 4
) (
   input  logic [ADDR_W-1:0]              addr,
   input  logic [NUM_CS-1:0][ADDR_W-1:0]  win_base,
   input  logic [NUM_CS-1:0][ADDR_W-1:0]  win_mask,
   input  logic [NUM_CS-1:0][WS_W-1:0]    win_ws,
   input  logic [NUM_CS-1:0]              win_en,
   output logic                           hit,
   output logic [cs_idx_w(NUM_CS)-1:0]    hit_idx,
   output logic [WS_W-1:0]                hit_ws
);

   localparam int IDX_W = cs_idx_w(NUM_CS);

   logic [NUM_CS-1:0] match;

   for (genvar k = 0; k < NUM_CS; k++) begin : g_cmp
      assign match[k] = win_en[k] &&
                        ((addr & win_mask[k]) == (win_base[k] & win_mask[k]));
   end

   // Scan from the top down so the lowest matching index is written last.
   always_comb begin
      hit     = |match;
      hit_idx = '0;
      hit_ws  = '0;
      for (int k = NUM_CS - 1; k >= 0; k--) begin
         if (match[k]) begin
            hit_idx = IDX_W'(k);
            hit_ws  = win_ws[k];
         end
      end
   end

endmodule

// File: rtl/addr_range_decoder_seq.sv
// addr_range_decoder_seq: programmable chip-select decoder with a req/ack
// bus-cycle FSM and per-window wait states.
//   clk, reset (async, active low)
//   bus_req/bus_addr     CPU request, address latched in IDLE
//   bus_ack/bus_err      one-cycle completion / unmapped pulses
//   cs_out               registered one-hot chip selects
//   busy                 FSM not in IDLE
//   cfg_we/idx/base/mask/ws/en   window table write port
module addr_range_decoder_seq
   import addr_decode_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int NUM_CS = 4,
   parameter int WS_W   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          bus_req,
   input  logic [ADDR_W-1:0]             bus_addr,
   output logic                          bus_ack,
   output logic                          bus_err,
   output logic [NUM_CS-1:0]             cs_out,
   output logic                          busy,
   input  logic                          cfg_we,
   input  logic [cs_idx_w(NUM_CS)-1:0]   cfg_idx,
   input  logic [ADDR_W-1:0]             cfg_base,
   input  logic [ADDR_W-1:0]             cfg_mask,
   input  logic [WS_W-1:0]               cfg_ws,
   input  logic                          cfg_en
);

   localparam int IDX_W = cs_idx_w(NUM_CS);

   // ---------------- window table ----------------
   logic [NUM_CS-1:0][ADDR_W-1:0] win_base, win_mask;
   logic [NUM_CS-1:0][WS_W-1:0]   win_ws;
   logic [NUM_CS-1:0]             win_en;

   for (genvar k = 0; k < NUM_CS; k++) begin : g_win
      localparam win_cfg_t RST = rst_win(k);
      logic [ADDR_W-1:0] base_q, mask_q;
      logic [WS_W-1:0]   ws_q;
      logic              en_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            base_q <= ADDR_W'(RST.base);
            mask_q <= ADDR_W'(RST.mask);
            ws_q   <= WS_W'(RST.ws);
            en_q   <= RST.en;
         end else if (cfg_we && cfg_idx == IDX_W'(k)) begin
            base_q <= cfg_base;
            mask_q <= cfg_mask;
            ws_q   <= cfg_ws;
            en_q   <= cfg_en;
         end
      end

      assign win_base[k] = base_q;
      assign win_mask[k] = mask_q;
      assign win_ws[k]   = ws_q;
      assign win_en[k]   = en_q;
   end

   // ---------------- decode ----------------
   logic [ADDR_W-1:0] addr_q;
   logic              hit;
   logic [IDX_W-1:0]  hit_idx;
   logic [WS_W-1:0]   hit_ws;

   addr_window_match #(
      .ADDR_W (ADDR_W),
      .NUM_CS (NUM_CS),
      .WS_W   (WS_W)
   ) u_match (
      .addr     (addr_q),
      .win_base (win_base),
      .win_mask (win_mask),
      .win_ws   (win_ws),
      .win_en   (win_en),
      .hit      (hit),
      .hit_idx  (hit_idx),
      .hit_ws   (hit_ws)
   );

   // ---------------- bus-cycle FSM ----------------
   state_t            state, state_nxt;
   logic [NUM_CS-1:0] cs_nxt;
   logic [WS_W-1:0]   cnt, cnt_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         cs_out <= '0;
         cnt    <= '0;
         addr_q <= '0;
      end else begin
         state  <= state_nxt;
         cs_out <= cs_nxt;
         cnt    <= cnt_nxt;
         if (state == ST_IDLE && bus_req)
            addr_q <= bus_addr;
      end
   end

   always_comb begin
      state_nxt = state;
      cs_nxt    = cs_out;
      cnt_nxt   = cnt;
      bus_ack   = 1'b0;
      bus_err   = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            busy   = 1'b0;
            cs_nxt = '0;
            if (bus_req)
               state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            // Abort wins over the decode result.
            if (!bus_req) begin
               state_nxt = ST_IDLE;
               cs_nxt    = '0;
            end else if (hit) begin
               state_nxt = ST_WAIT;
               cs_nxt    = NUM_CS'(1) << hit_idx;
               cnt_nxt   = hit_ws;
            end else begin
               state_nxt = ST_ERR;
               cs_nxt    = '0;
            end
         end
         ST_WAIT: begin
            if (!bus_req) begin
               state_nxt = ST_IDLE;
               cs_nxt    = '0;
            end else if (cnt == '0) begin
               state_nxt = ST_DONE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_DONE: begin
            bus_ack   = 1'b1;
            state_nxt = ST_IDLE;
            cs_nxt    = '0;
         end
         ST_ERR: begin
            bus_err   = 1'b1;
            state_nxt = ST_IDLE;
            cs_nxt    = '0;
         end
         default: begin
            state_nxt = ST_IDLE;
            cs_nxt    = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_addr_range_decoder_seq.sv
module tb_addr_range_decoder_seq;

   localparam int ADDR_W = 32;
   localparam int NUM_CS = 4;
   localparam int WS_W   = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              bus_req = 1'b0;
   logic [31:0]       bus_addr = '0;
   logic              bus_ack, bus_err, busy;
   logic [3:0]        cs_out;
   logic              cfg_we = 1'b0;
   logic [1:0]        cfg_idx = '0;
   logic [31:0]       cfg_base = '0, cfg_mask = '0;
   logic [3:0]        cfg_ws = '0;
   logic              cfg_en = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   addr_range_decoder_seq #(.ADDR_W(ADDR_W), .NUM_CS(NUM_CS), .WS_W(WS_W)) dut (
      .clk(clk), .reset(reset), .bus_req(bus_req), .bus_addr(bus_addr),
      .bus_ack(bus_ack), .bus_err(bus_err), .cs_out(cs_out), .busy(busy),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base),
      .cfg_mask(cfg_mask), .cfg_ws(cfg_ws), .cfg_en(cfg_en)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model: the window table ----------------
   logic [31:0] m_base [4];
   logic [31:0] m_mask [4];
   int          m_ws   [4];
   bit          m_en   [4];

   function automatic void model_reset();
      m_base = '{32'hFFF0_0000, 32'h0000_0000, 32'hC000_0000, 32'h0};
      m_mask = '{32'hFFF8_0000, 32'hFFF8_0000, 32'hFFF8_0000, 32'h0};
      m_ws   = '{2, 0, 4, 0};
      m_en   = '{1'b1, 1'b1, 1'b1, 1'b0};
   endfunction

   function automatic void model_decode(input logic [31:0] a, output bit hit, output int idx);
      hit = 1'b0;
      idx = 0;
      for (int k = 0; k < 4; k++) begin
         if (!hit && m_en[k] && ((a & m_mask[k]) == (m_base[k] & m_mask[k]))) begin
            hit = 1'b1;
            idx = k;
         end
      end
   endfunction

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      bit         err;
      logic [3:0] cs;
      int         due;
   } exp_t;
   exp_t sb_q[$];

   always @(negedge clk) begin
      if (reset) begin
         check("ack_err_excl", {63'd0, bus_ack & bus_err}, 64'd0);
         check("cs_onehot0", {63'd0, $countones(cs_out) > 1}, 64'd0);
         if (bus_ack || bus_err) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected", {62'd0, bus_ack, bus_err}, 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_kind_err", {63'd0, bus_err}, {63'd0, e.err});
               check("sb_cs", {60'd0, cs_out}, {60'd0, e.cs});
               check("sb_time", 64'(cyc), 64'(e.due));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cfg_write(input int i, input logic [31:0] b, input logic [31:0] m,
                            input int ws, input bit en);
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = 2'(i); cfg_base = b; cfg_mask = m;
      cfg_ws = 4'(ws); cfg_en = en;
      @(negedge clk);
      cfg_we = 1'b0;
      m_base[i] = b; m_mask[i] = m; m_ws[i] = ws; m_en[i] = en;
   endtask

   task automatic do_req(input logic [31:0] a);
      bit   hit;
      int   idx, n, e0;
      exp_t e;
      model_decode(a, hit, idx);
      @(negedge clk);
      bus_req = 1'b1; bus_addr = a;
      e0 = cyc + 1;
      e.err = !hit;
      e.cs  = hit ? 4'(1 << idx) : 4'd0;
      e.due = hit ? e0 + m_ws[idx] + 2 : e0 + 1;
      sb_q.push_back(e);
      @(negedge clk);
      @(negedge clk);
      check("cs_after_e1", {60'd0, cs_out}, {60'd0, e.cs});
      n = 0;
      while (!(bus_ack || bus_err) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("req_timeout", 64'd1, 64'd0);
      bus_req = 1'b0;
      @(negedge clk);
      check("cs_fall", {60'd0, cs_out}, 64'd0);
      check("idle_after", {62'd0, busy, bus_ack}, 64'd0);
   endtask

   logic [31:0] ra;
   int          rk;
   bit          rh;
   int          ri;

   initial begin
      model_reset();
      #1;
      check("rst_cs", {60'd0, cs_out}, 64'd0);
      check("rst_flags", {61'd0, bus_ack, bus_err, busy}, 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Directed cases
      do_req(32'hFFF0_1234);
      do_req(32'h0000_0010);
      do_req(32'hC000_0000);
      do_req(32'h8000_0000);
      cfg_write(3, 32'h8000_0000, 32'hF000_0000, 1, 1'b1);
      do_req(32'h8000_0004);
      cfg_write(1, 32'h0000_0000, 32'h0000_0000, 0, 1'b1);
      do_req(32'h8000_0004);
      cfg_write(1, 32'h0000_0000, 32'hFFF8_0000, 0, 1'b1);

      // Abort during WAIT of a ROM access
      @(negedge clk);
      bus_req = 1'b1; bus_addr = 32'hFFF0_0040;
      @(negedge clk);
      @(negedge clk);
      check("abort_cs_on", {60'd0, cs_out}, 64'h1);
      bus_req = 1'b0;
      @(negedge clk);
      check("abort_cs_clr", {60'd0, cs_out}, 64'd0);
      check("abort_idle", {63'd0, busy}, 64'd0);
      repeat (6) @(negedge clk);

      // Reset in the middle of a DRAM access
      bus_req = 1'b1; bus_addr = 32'hC000_0100;
      repeat (3) @(negedge clk);
      check("pre_rst_cs", {60'd0, cs_out}, 64'h4);
      reset = 1'b0;
      #1;
      check("mid_rst_cs", {60'd0, cs_out}, 64'd0);
      check("mid_rst_flags", {61'd0, bus_ack, bus_err, busy}, 64'd0);
      bus_req = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      do_req(32'h8000_0004);
      do_req(32'hFFF0_0000);

      // Randomized traffic with occasional table rewrites
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0: ra = 32'h0;
               1: ra = 32'hF000_0000;
               2: ra = 32'hFFF8_0000;
               default: ra = $urandom();
            endcase
            cfg_write($urandom_range(0, 3), $urandom(), ra,
                      $urandom_range(0, 7), $urandom_range(0, 1) == 1);
         end
         if ($urandom_range(0, 1) == 0) begin
            ra = $urandom();
         end else begin
            rk = $urandom_range(0, 3);
            ra = (m_base[rk] & m_mask[rk]) | ($urandom() & ~m_mask[rk]);
         end
         model_decode(ra, rh, ri);
         do_req(ra);
      end

      repeat (4) @(negedge clk);
      check("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
